// File: rtl/bcd_upcount_timer.sv
// Multi-digit BCD count-up timer with an internal prescaler.
// Counts from zero up to a latched, digit-clamped limit, then holds and flags done.
module bcd_upcount_timer #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000000,
  parameter int PW       = 26
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pause,
  input  logic                clear,
  input  logic [4*DIGITS-1:0] limit_bcd,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic                running,
  output logic                done,
  output logic                done_pulse,
  output logic                tick
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [1:0]          state;
  logic [1:0]          state_nx;
  logic [PW-1:0]       presc;
  logic [4*DIGITS-1:0] limit_q;
  logic [4*DIGITS-1:0] limit_clamped;
  logic [4*DIGITS-1:0] count_inc;
  logic                do_latch;
  logic                do_zero;
  logic                do_advance;
  logic                do_inc;
  logic                zero_entry;

  always_comb begin
    limit_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      limit_clamped[4*i +: 4] = (limit_bcd[4*i +: 4] > 4'd9) ? 4'd9 : limit_bcd[4*i +: 4];
    end
  end

  // Decimal carry ripples upward: a digit steps only when every lower digit is 9.
  always_comb begin
    logic carry;
    carry     = 1'b1;
    count_inc = count_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        count_inc[4*i +: 4] = (count_bcd[4*i +: 4] == 4'd9) ? 4'd0 : count_bcd[4*i +: 4] + 4'd1;
      end
      carry = carry && (count_bcd[4*i +: 4] == 4'd9);
    end
  end

  always_comb begin
    state_nx   = state;
    do_latch   = 1'b0;
    do_zero    = 1'b0;
    do_advance = 1'b0;
    do_inc     = 1'b0;
    zero_entry = 1'b0;
    if (clear) begin
      state_nx = S_IDLE;
      do_zero  = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_nx = S_RUN;
            do_latch = 1'b1;
            do_zero  = 1'b1;
          end
        end
        S_RUN: begin
          if (pause) begin
            state_nx = S_PAUSE;
          end else if (limit_q == '0) begin
            state_nx   = S_DONE;
            zero_entry = 1'b1;
          end else begin
            do_advance = 1'b1;
            if (presc == PRESC_LAST) begin
              do_inc = 1'b1;
              if (count_inc == limit_q) state_nx = S_DONE;
            end
          end
        end
        S_PAUSE: begin
          if (start) state_nx = S_RUN;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // done lags the terminal count by one cycle; a zero limit has no count change, so it flags at once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      presc      <= '0;
      count_bcd  <= '0;
      limit_q    <= '0;
      tick       <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state   <= state_nx;
      tick    <= do_inc;
      running <= (state_nx == S_RUN);
      if (do_latch) limit_q <= limit_clamped;
      if (do_zero) begin
        presc     <= '0;
        count_bcd <= '0;
      end else if (do_advance) begin
        presc <= do_inc ? '0 : presc + PW'(1);
        if (do_inc) count_bcd <= count_inc;
      end
      if (state == S_DONE && state_nx == S_DONE) begin
        done       <= 1'b1;
        done_pulse <= !done;
      end else if (zero_entry) begin
        done       <= 1'b1;
        done_pulse <= 1'b1;
      end else begin
        done       <= 1'b0;
        done_pulse <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_upcount_timer.sv
// Scoreboard bench for bcd_upcount_timer: a decimal behavioural model queues the expected
// outputs for every driven cycle, and targeted checks pin down the directed scenarios.
module tb_bcd_upcount_timer;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;
  localparam int PW       = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] limit_bcd = '0;
  logic [15:0] count_bcd;
  logic        running;
  logic        done;
  logic        done_pulse;
  logic        tick;

  bcd_upcount_timer #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .PW(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .clear      (clear),
    .limit_bcd  (limit_bcd),
    .count_bcd  (count_bcd),
    .running    (running),
    .done       (done),
    .done_pulse (done_pulse),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [19:0] expq[$];
  int          m_state = M_IDLE;
  int          m_count = 0;
  int          m_presc = 0;
  int          m_limit = 0;
  logic        m_done = 1'b0;
  logic        m_pulse = 1'b0;
  logic        m_tick = 1'b0;
  int          pulse_cnt = 0;
  int          tick_cnt = 0;
  int          snap;
  logic [15:0] cur_lim = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampLimit(input logic [15:0] lim);
    int v = 0;
    int scale = 1;
    int d;
    for (int i = 0; i < 4; i++) begin
      d = int'(lim[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * scale;
      scale *= 10;
    end
    return v;
  endfunction

  function automatic logic [15:0] toBcd(input int v);
    logic [15:0] b = '0;
    int rem = v;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return b;
  endfunction

  function automatic logic bcdValid(input logic [15:0] b);
    logic ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic modelStep(input logic r, input logic s, input logic p, input logic c, input logic [15:0] lim);
    m_tick  = 1'b0;
    m_pulse = 1'b0;
    if (!r) begin
      m_state = M_IDLE;
      m_count = 0;
      m_presc = 0;
      m_limit = 0;
      m_done  = 1'b0;
    end else if (c) begin
      m_state = M_IDLE;
      m_count = 0;
      m_presc = 0;
      m_done  = 1'b0;
    end else begin
      case (m_state)
        M_IDLE: if (s) begin
          m_state = M_RUN;
          m_limit = clampLimit(lim);
          m_count = 0;
          m_presc = 0;
        end
        M_RUN: begin
          if (p) m_state = M_PAUSE;
          else if (m_limit == 0) begin
            m_state = M_DONE;
            m_done  = 1'b1;
            m_pulse = 1'b1;
          end else if (m_presc == TICK_DIV - 1) begin
            m_presc = 0;
            m_count++;
            m_tick = 1'b1;
            if (m_count == m_limit) m_state = M_DONE;
          end else m_presc++;
        end
        M_PAUSE: if (s) m_state = M_RUN;
        default: begin
          if (s) begin
            m_state = M_RUN;
            m_limit = clampLimit(lim);
            m_count = 0;
            m_presc = 0;
            m_done  = 1'b0;
          end else if (!m_done) begin
            m_done  = 1'b1;
            m_pulse = 1'b1;
          end
        end
      endcase
    end
    expq.push_back({toBcd(m_count), (m_state == M_RUN), m_done, m_pulse, m_tick});
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic p, input logic c, input logic [15:0] lim);
    logic [19:0] exp;
    rst       = r;
    start     = s;
    pause     = p;
    clear     = c;
    limit_bcd = lim;
    modelStep(r, s, p, c, lim);
    @(posedge clk);
    #1;
    exp = expq.pop_front();
    checkOutput("cycle", {count_bcd, running, done, done_pulse, tick}, exp);
    checkOutput("bcd_digits", bcdValid(count_bcd), 1);
    if (done_pulse) pulse_cnt++;
    if (tick) tick_cnt++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, cur_lim);
  endtask

  initial begin
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h1234);
    checkOutput("reset_state", {count_bcd, running, done, done_pulse, tick}, 0);

    // Count to 0012; limit changes after the latch must be ignored.
    tick_cnt = 0;
    pulse_cnt = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0012);
    cur_lim = 16'h0003;
    runCycles(48);
    checkOutput("lim12_count", count_bcd, 16'h0012);
    checkOutput("lim12_ticks", tick_cnt, 12);
    checkOutput("lim12_done_lag", done, 0);
    runCycles(1);
    checkOutput("lim12_pulse", done_pulse, 1);
    checkOutput("lim12_done", done, 1);
    runCycles(10);
    checkOutput("lim12_hold", count_bcd, 16'h0012);
    checkOutput("lim12_pulse_once", pulse_cnt, 1);
    checkOutput("lim12_done_hold", done, 1);

    // Restart from DONE with a full-range limit and exercise the carry ripple.
    cur_lim = 16'h9999;
    tick_cnt = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, cur_lim);
    checkOutput("restart_count", count_bcd, 16'h0000);
    checkOutput("restart_done", done, 0);
    runCycles(396);
    checkOutput("ripple_0099", count_bcd, 16'h0099);
    runCycles(4);
    checkOutput("ripple_0100", count_bcd, 16'h0100);
    runCycles(3596);
    checkOutput("ripple_0999", count_bcd, 16'h0999);
    runCycles(4);
    checkOutput("ripple_1000", count_bcd, 16'h1000);
    checkOutput("ripple_ticks", tick_cnt, 1000);

    // Pause mid-period at 0005, hold, then resume from the held prescaler.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, cur_lim);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, cur_lim);
    runCycles(20);
    checkOutput("pause_pre_count", count_bcd, 16'h0005);
    runCycles(2);
    snap = tick_cnt;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, cur_lim);
    checkOutput("pause_running", running, 0);
    runCycles(9);
    checkOutput("pause_hold_count", count_bcd, 16'h0005);
    checkOutput("pause_no_tick", tick_cnt, snap);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, cur_lim);
    checkOutput("resume_running", running, 1);
    runCycles(1);
    checkOutput("resume_early_tick", tick, 0);
    runCycles(1);
    checkOutput("resume_tick", tick, 1);
    checkOutput("resume_count", count_bcd, 16'h0006);

    // Command priority inside RUN.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, cur_lim);
    checkOutput("prio_all_running", running, 0);
    checkOutput("prio_all_count", count_bcd, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, cur_lim);
    runCycles(6);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, cur_lim);
    checkOutput("prio_ps_running", running, 0);
    runCycles(8);
    checkOutput("prio_ps_hold", count_bcd, 16'h0001);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, cur_lim);

    // Out-of-range digits clamp to 9.
    cur_lim = 16'h00AF;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, cur_lim);
    runCycles(396);
    checkOutput("clamp_count", count_bcd, 16'h0099);
    runCycles(1);
    checkOutput("clamp_done", done, 1);
    runCycles(3);
    checkOutput("clamp_hold", count_bcd, 16'h0099);

    // Zero limit: done at once, never a tick.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, cur_lim);
    cur_lim = 16'h0000;
    pulse_cnt = 0;
    snap = tick_cnt;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, cur_lim);
    checkOutput("zero_running", running, 1);
    runCycles(1);
    checkOutput("zero_pulse", done_pulse, 1);
    checkOutput("zero_done", done, 1);
    runCycles(5);
    checkOutput("zero_pulse_once", pulse_cnt, 1);
    checkOutput("zero_no_tick", tick_cnt, snap);
    checkOutput("zero_count", count_bcd, 16'h0000);

    // Reset mid-run aborts without a done pulse.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, cur_lim);
    cur_lim = 16'h9999;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, cur_lim);
    runCycles(148);
    checkOutput("abort_pre_count", count_bcd, 16'h0037);
    snap = pulse_cnt;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, cur_lim);
    checkOutput("abort_outputs", {count_bcd, running, done, done_pulse, tick}, 0);
    runCycles(3);
    checkOutput("abort_no_pulse", pulse_cnt, snap);
    checkOutput("abort_idle", running, 0);

    // Random command mix against the model.
    for (int i = 0; i < 800; i++) begin
      logic r, s, p, c;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 4))
          0: cur_lim = 16'h0000;
          1: cur_lim = 16'h0003;
          2: cur_lim = 16'h0012;
          3: cur_lim = 16'h00A2;
          default: cur_lim = 16'($urandom_range(0, 65535)) & 16'h00FF;
        endcase
      end
      r = ($urandom_range(0, 299) != 0);
      s = ($urandom_range(0, 19) == 0);
      p = ($urandom_range(0, 24) == 0);
      c = ($urandom_range(0, 59) == 0);
      applyStimulus(r, s, p, c, cur_lim);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
